// File: rtl/stage_mem.sv
// MEM pipeline stage: byte-lane data memory, branch resolve, MEM/WB latch.
// Latency: branch outputs combinational; load data and WB fields 1 cycle.
// Backpressure: none; a new access is accepted every cycle, no stall path.
module stage_mem #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inAlu,
  input  logic        inZeroAlu,
  input  logic [31:0] inDataRt,
  input  logic [31:0] inAddEx,
  input  logic [4:0]  inMuxRtRd,
  input  logic [1:0]  inMemtoReg,
  input  logic        inRegWrite,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inBranch,
  input  logic [2:0]  inflagLoadWordDividerMEM,
  input  logic [1:0]  inflagStoreWordDividerMEM,
  output logic        outPCSrc,
  output logic [31:0] outBranchTarget,
  output logic [31:0] outReadData,
  output logic [31:0] outAluWb,
  output logic [4:0]  outMuxRtRdWb,
  output logic [1:0]  outMemtoRegWb,
  output logic        outRegWriteWb
);

  localparam int AW = $clog2(MEM_WORDS);

  // Memory is plain flops so that reset can clear every word in one edge.
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] mem_d [MEM_WORDS];

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_wb_q, alu_wb_d;
  logic [4:0]  mux_rt_rd_wb_q, mux_rt_rd_wb_d;
  logic [1:0]  mem_to_reg_wb_q, mem_to_reg_wb_d;
  logic        reg_write_wb_q, reg_write_wb_d;

  // Upper address bits are dropped, so accesses wrap around the array.
  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic [31:0]   wr_word;
  logic [31:0]   load_data;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign word_idx = inAlu[AW+1:2];
  assign cur_word = mem_q[word_idx];

  // Branch resolution is purely combinational and ignores reset.
  assign outPCSrc        = inBranch & inZeroAlu;
  assign outBranchTarget = inAddEx;

  // Merge store data into the addressed word; untouched lanes keep old bytes.
  always_comb begin
    wr_word = cur_word;
    case (inflagStoreWordDividerMEM)
      2'b00: wr_word = inDataRt;
      2'b01: begin
        if (inAlu[1]) wr_word[31:16] = inDataRt[15:0];
        else          wr_word[15:0]  = inDataRt[15:0];
      end
      2'b10: begin
        case (inAlu[1:0])
          2'b00:   wr_word[7:0]   = inDataRt[7:0];
          2'b01:   wr_word[15:8]  = inDataRt[7:0];
          2'b10:   wr_word[23:16] = inDataRt[7:0];
          default: wr_word[31:24] = inDataRt[7:0];
        endcase
      end
      default: wr_word = cur_word;
    endcase
  end

  // Next memory image: only an enabled store with a real width changes it.
  always_comb begin
    mem_d = mem_q;
    if (inMemWrite && (inflagStoreWordDividerMEM != 2'b11)) begin
      mem_d[word_idx] = wr_word;
    end
  end

  // Load extraction works on the pre-edge word, giving read-before-write.
  always_comb begin
    half_sel  = inAlu[1] ? cur_word[31:16] : cur_word[15:0];
    case (inAlu[1:0])
      2'b00:   byte_sel = cur_word[7:0];
      2'b01:   byte_sel = cur_word[15:8];
      2'b10:   byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
    case (inflagLoadWordDividerMEM)
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = {16'h0000, half_sel};
      3'b011:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      default: load_data = cur_word;
    endcase
  end

  // MEM/WB next values; read data is zero when no load is in flight.
  always_comb begin
    read_data_d     = inMemRead ? load_data : 32'h0;
    alu_wb_d        = inAlu;
    mux_rt_rd_wb_d  = inMuxRtRd;
    mem_to_reg_wb_d = inMemtoReg;
    reg_write_wb_d  = inRegWrite;
  end

  // State update; reset wipes the latch and the whole memory, blocking stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q     <= '0;
      alu_wb_q        <= '0;
      mux_rt_rd_wb_q  <= '0;
      mem_to_reg_wb_q <= '0;
      reg_write_wb_q  <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      read_data_q     <= read_data_d;
      alu_wb_q        <= alu_wb_d;
      mux_rt_rd_wb_q  <= mux_rt_rd_wb_d;
      mem_to_reg_wb_q <= mem_to_reg_wb_d;
      reg_write_wb_q  <= reg_write_wb_d;
      mem_q           <= mem_d;
    end
  end

  assign outReadData   = read_data_q;
  assign outAluWb      = alu_wb_q;
  assign outMuxRtRdWb  = mux_rt_rd_wb_q;
  assign outMemtoRegWb = mem_to_reg_wb_q;
  assign outRegWriteWb = reg_write_wb_q;

endmodule
